// File: rtl/uart_router_pkg.sv
// Shared mode constants, FSM encoding and ASCII helper for the UART stream router.
package uart_router_pkg;

  localparam logic [1:0] MODE_ECHO    = 2'b00;
  localparam logic [1:0] MODE_UPPER   = 2'b01;
  localparam logic [1:0] MODE_LINE    = 2'b10;
  localparam logic [1:0] MODE_DISCARD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_XMIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Lower-case ASCII letters map to upper case; every other byte passes through.
  function automatic logic [7:0] ascii_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b - 8'h20;
    end
    return b;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Line storage: register array with one synchronous write port and an asynchronous read port.
module line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write one entry per cycle; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_stream_router.sv
// Moves bytes from the UART RX FIFO to the TX FIFO in echo, upper-case, line-buffered or discard mode.
module uart_stream_router
  import uart_router_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           LINE_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR = DATA_WIDTH'(8'h0D),
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  clr_stats,
  input  logic                  rx_fifo_empty,
  input  logic [DATA_WIDTH-1:0] rx_fifo_dout,
  output logic                  rx_fifo_rd_en,
  input  logic                  tx_fifo_full,
  output logic                  tx_fifo_wr_en,
  output logic [DATA_WIDTH-1:0] tx_fifo_din,
  output logic [CNT_WIDTH-1:0]  rx_count,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic                  line_overflow,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(LINE_DEPTH);
  localparam int unsigned CW = AW + 1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] fetch_byte;
  logic [CW-1:0]         line_cnt_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic                  buf_we;
  logic                  ovf_set;
  logic                  drain_last;

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (LINE_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (line_cnt_q[AW-1:0]),
    .wdata (rx_fifo_dout),
    .raddr (rd_ptr_q),
    .rdata (buf_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and FIFO strobes; strobes are held low while reset is asserted.
  always_comb begin
    state_d       = state_q;
    rx_fifo_rd_en = 1'b0;
    tx_fifo_wr_en = 1'b0;
    tx_fifo_din   = '0;
    buf_we        = 1'b0;
    ovf_set       = 1'b0;
    drain_last    = ({1'b0, rd_ptr_q} == line_cnt_q - CW'(1));
    unique case (state_q)
      ST_IDLE: begin
        if (mode != MODE_LINE && line_cnt_q != '0) begin
          state_d = ST_DRAIN;
        end else if (!rx_fifo_empty) begin
          rx_fifo_rd_en = rst;
          state_d       = ST_FETCH;
        end
      end
      ST_FETCH: begin
        case (mode)
          MODE_ECHO, MODE_UPPER: state_d = ST_XMIT;
          MODE_LINE: begin
            buf_we = 1'b1;
            if (rx_fifo_dout == TERMINATOR) begin
              state_d = ST_DRAIN;
            end else if (line_cnt_q == CW'(LINE_DEPTH - 1)) begin
              state_d = ST_DRAIN;
              ovf_set = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_XMIT: begin
        if (!tx_fifo_full) begin
          tx_fifo_wr_en = rst;
          tx_fifo_din   = data_q;
          state_d       = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!tx_fifo_full) begin
          tx_fifo_wr_en = rst;
          tx_fifo_din   = buf_rdata;
          if (drain_last) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Upper-case conversion only makes sense for 8-bit ASCII data.
  always_comb begin
    fetch_byte = rx_fifo_dout;
    if (DATA_WIDTH == 8 && mode == MODE_UPPER) begin
      fetch_byte = DATA_WIDTH'(ascii_upper(8'(rx_fifo_dout)));
    end
  end

  // Fetched byte register and line-buffer pointers; rd_ptr stays 0 while a line is filling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q     <= '0;
      line_cnt_q <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (state_q == ST_FETCH) begin
        data_q <= fetch_byte;
      end
      if (buf_we) begin
        line_cnt_q <= line_cnt_q + CW'(1);
      end
      if (state_q == ST_DRAIN && tx_fifo_wr_en) begin
        if (drain_last) begin
          rd_ptr_q   <= '0;
          line_cnt_q <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

  // Byte counters and sticky overflow; a clear beats any same-cycle update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_count      <= '0;
      tx_count      <= '0;
      line_overflow <= 1'b0;
    end else if (clr_stats) begin
      rx_count      <= '0;
      tx_count      <= '0;
      line_overflow <= 1'b0;
    end else begin
      if (state_q == ST_FETCH) begin
        rx_count <= rx_count + CNT_WIDTH'(1);
      end
      if (tx_fifo_wr_en) begin
        tx_count <= tx_count + CNT_WIDTH'(1);
      end
      if (ovf_set) begin
        line_overflow <= 1'b1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_stream_router.sv
// Scoreboard bench for uart_stream_router with modelled RX/TX FIFOs and a mode-level reference model.
module tb_uart_stream_router;
  import uart_router_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 16;
  localparam logic [7:0]  TERM  = 8'h0D;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic            clr_stats = 1'b0;
  logic            rx_fifo_empty = 1'b1;
  logic [DW-1:0]   rx_fifo_dout = '0;
  logic            rx_fifo_rd_en;
  logic            tx_fifo_full = 1'b0;
  logic            tx_fifo_wr_en;
  logic [DW-1:0]   tx_fifo_din;
  logic [CNTW-1:0] rx_count;
  logic [CNTW-1:0] tx_count;
  logic            line_overflow;
  logic            busy;

  always #5 clk = ~clk;

  uart_stream_router #(
    .DATA_WIDTH (DW),
    .LINE_DEPTH (DEPTH),
    .TERMINATOR (TERM),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .clr_stats     (clr_stats),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_dout  (rx_fifo_dout),
    .rx_fifo_rd_en (rx_fifo_rd_en),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_din   (tx_fifo_din),
    .rx_count      (rx_count),
    .tx_count      (tx_count),
    .line_overflow (line_overflow),
    .busy          (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [7:0] line_q[$];
  int         wr_cyc_q[$];
  logic [1:0] cur_mode = MODE_ECHO;
  int         rx_model = 0;
  int         tx_model = 0;
  bit         ovf_model = 1'b0;
  int         full_pct = 0;
  int         hold_cnt = 0;
  bit         rd_pending = 1'b0;
  bit         prev_rd = 1'b0;
  int         last_rd_cyc = -100;
  int         rd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: protocol checks and scoreboard compare, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("reset_rd_en", 32'(rx_fifo_rd_en), 0);
      check("reset_wr_en", 32'(tx_fifo_wr_en), 0);
    end else begin
      if (rx_fifo_rd_en) begin
        check("rd_en_while_empty", 32'(rx_fifo_empty), 0);
        check("rd_en_spacing", 32'(prev_rd), 0);
        rd_pending  = 1'b1;
        last_rd_cyc = cyc;
        rd_seen++;
      end
      if (tx_fifo_wr_en) begin
        check("wr_en_while_full", 32'(tx_fifo_full), 0);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got %0h, required no byte", tx_fifo_din);
        end else begin
          check("tx_byte", 32'(tx_fifo_din), 32'(expq.pop_front()));
        end
        wr_cyc_q.push_back(cyc);
      end
    end
    prev_rd = rx_fifo_rd_en;
  end

  // RX/TX FIFO models: pop on a sampled rd_en, drive full from a hold count or random draw.
  always @(posedge clk) begin
    #1;
    if (rd_pending && rxq.size() > 0) begin
      rx_fifo_dout = rxq.pop_front();
    end
    rd_pending    = 1'b0;
    rx_fifo_empty = (rxq.size() == 0);
    if (hold_cnt > 0) begin
      tx_fifo_full = 1'b1;
      hold_cnt--;
    end else begin
      tx_fifo_full = ($urandom_range(99) < full_pct);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: what each received byte must eventually produce on TX.
  task automatic model_byte(input logic [7:0] b);
    rx_model++;
    case (cur_mode)
      MODE_ECHO: begin
        expq.push_back(b);
        tx_model++;
      end
      MODE_UPPER: begin
        expq.push_back((b inside {[8'h61:8'h7A]}) ? b - 8'h20 : b);
        tx_model++;
      end
      MODE_LINE: begin
        line_q.push_back(b);
        if (b == TERM || line_q.size() == DEPTH) begin
          if (b != TERM) ovf_model = 1'b1;
          while (line_q.size() > 0) begin
            expq.push_back(line_q.pop_front());
            tx_model++;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rxq.push_back(b);
    rx_fifo_empty = 1'b0;
    model_byte(b);
  endtask

  task automatic set_mode(input logic [1:0] m);
    if (m != MODE_LINE) begin
      while (line_q.size() > 0) begin
        expq.push_back(line_q.pop_front());
        tx_model++;
      end
    end
    cur_mode = m;
    @(posedge clk);
    #1;
    mode = m;
  endtask

  task automatic quiesce(input string tag);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (rxq.size() == 0 && !busy) stable++;
      else stable = 0;
    end
    check({tag, "_settle"}, 32'(stable >= 3), 1);
  endtask

  task automatic checkpoint(input string tag);
    quiesce(tag);
    check({tag, "_pending"}, 32'(expq.size()), 0);
    check({tag, "_rx_count"}, 32'(rx_count), 32'(CNTW'(rx_model)));
    check({tag, "_tx_count"}, 32'(tx_count), 32'(CNTW'(tx_model)));
    check({tag, "_overflow"}, 32'(line_overflow), 32'(ovf_model));
  endtask

  task automatic clear_model();
    rx_model  = 0;
    tx_model  = 0;
    ovf_model = 1'b0;
  endtask

  initial begin
    int sz;
    int rd0;
    int n;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_rx_count", 32'(rx_count), 0);
    check("rst_tx_count", 32'(tx_count), 0);
    check("rst_overflow", 32'(line_overflow), 0);
    check("rst_din", 32'(tx_fifo_din), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Echo: single byte, latency rd_en -> wr_en of two cycles
    set_mode(MODE_ECHO);
    send(8'h61);
    checkpoint("echo");
    check("echo_latency", 32'(wr_cyc_q[$] - last_rd_cyc), 2);

    // Upper-case echo
    set_mode(MODE_UPPER);
    send(8'h61); send(8'h7A); send(8'h7B); send(8'h41);
    checkpoint("upper");

    // Line mode: nothing until the terminator, then a back-to-back burst
    set_mode(MODE_LINE);
    sz = wr_cyc_q.size();
    send(8'h48); send(8'h49);
    repeat (8) @(negedge clk);
    check("line_hold_no_wr", 32'(wr_cyc_q.size()), 32'(sz));
    send(TERM);
    checkpoint("line_hi");
    n = wr_cyc_q.size();
    check("line_burst", 32'(wr_cyc_q[n-1] - wr_cyc_q[n-3]), 2);

    // Overflow then clear
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    checkpoint("line_ovf");
    @(posedge clk); #1; clr_stats = 1'b1;
    @(posedge clk); #1; clr_stats = 1'b0;
    clear_model();
    checkpoint("clr");

    // Clear held through traffic: clear wins over increments and overflow set
    clr_stats = 1'b1;
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    quiesce("clr_hold");
    @(posedge clk); #1; clr_stats = 1'b0;
    clear_model();
    checkpoint("clr_hold");

    // Backpressure in echo: no push and no new pop while TX is full
    set_mode(MODE_ECHO);
    send(8'h10);
    @(posedge clk); #2; hold_cnt = 12; tx_fifo_full = 1'b1;
    send(8'h11); send(8'h12);
    repeat (4) @(negedge clk);
    rd0 = rd_seen;
    sz  = wr_cyc_q.size();
    repeat (6) @(negedge clk);
    check("hold_no_rd", 32'(rd_seen), 32'(rd0));
    check("hold_no_wr", 32'(wr_cyc_q.size()), 32'(sz));
    checkpoint("echo_hold");

    // Backpressure in line drain
    set_mode(MODE_LINE);
    @(posedge clk); #2; hold_cnt = 12; tx_fifo_full = 1'b1;
    send(8'h31); send(8'h32); send(TERM);
    checkpoint("drain_hold");

    // Reset in the middle of a stalled drain
    @(posedge clk); #2; hold_cnt = 40; tx_fifo_full = 1'b1;
    send(8'h41); send(8'h42); send(TERM);
    repeat (10) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    expq.delete();
    line_q.delete();
    clear_model();
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rx_count", 32'(rx_count), 0);
    check("mid_rst_tx_count", 32'(tx_count), 0);
    sz = wr_cyc_q.size();
    repeat (12) @(negedge clk);
    check("post_rst_no_wr", 32'(wr_cyc_q.size()), 32'(sz));
    @(posedge clk); #2; hold_cnt = 0;
    send(8'h58); send(TERM);
    checkpoint("after_rst");

    // Mode change flushes a partial line ahead of the next byte
    send(8'h41); send(8'h42);
    quiesce("partial");
    set_mode(MODE_ECHO);
    send(8'h43);
    checkpoint("flush");

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      set_mode(2'($urandom_range(3)));
      case ($urandom_range(2))
        0: full_pct = 0;
        1: full_pct = 30;
        default: full_pct = 70;
      endcase
      n = int'($urandom_range(10, 1));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(5))
          0, 1: b = 8'(8'h61 + $urandom_range(25));
          2: b = TERM;
          default: b = 8'($urandom_range(255));
        endcase
        send(b);
        repeat ($urandom_range(2)) @(posedge clk);
      end
      checkpoint("rand");
    end
    full_pct = 0;
    set_mode(MODE_ECHO);
    checkpoint("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
